load_store_unit: RTL and testbench

//  Memory stage of the rv32i core: takes one LOAD/STORE per handshake from execute
//  (effective address, funct3, store data). Drives a req/gnt/rvalid data-memory port

---
 rtl/load_store_unit_pkg.sv | 63 ++++++
 rtl/load_align_ext.sv | 41 ++++
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg
// Shared load/store definitions: funct3 encodings, output-port address,
// LSU state encoding and small decode helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } funct3_t;

  localparam logic [31:0] OUTPORT_ADDR = 32'h0000fffc;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } lsu_state_t;

  // Unsigned sub-word variants only exist for loads.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    case (f3)
      3'b011, 3'b110, 3'b111: return 1'b1;
      3'b100, 3'b101:         return store;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      HALF, HALF_U: return lane[0];
      WORD:         return lane != 2'b00;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align_ext.sv
// ============================================================================
// load_align_ext
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align_ext
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (lane_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    // Halves are only ever aligned, so lane bit 1 picks the half.
    w_half = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      BYTE:    result_o = {{24{w_byte[7]}}, w_byte};
      HALF:    result_o = {{16{w_half[15]}}, w_half};
      BYTE_U:  result_o = {24'b0, w_byte};
      HALF_U:  result_o = {16'b0, w_half};
      default: result_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// Memory stage: one load/store per handshake onto a req/gnt/rvalid port,
// plus the memory-mapped output port register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] OUTPORT_ADDR = load_store_unit_pkg::OUTPORT_ADDR,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_store_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_done_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] out_port_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] out_q, out_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic        mwe_q, mwe_d;

  logic        w_accept;
  logic        w_outport;
  logic        w_acc_err;
  logic [1:0]  w_lane;
  logic [2:0]  w_f3;
  logic [31:0] w_src;
  logic [31:0] w_ext;

  assign w_accept  = lsu_valid_i && (state_q == IDLE);
  assign w_outport = (lsu_addr_i[31:2] == OUTPORT_ADDR[31:2]);
  assign w_acc_err = f3_illegal(lsu_store_i, lsu_funct3_i)
                  || misaligned(lsu_funct3_i, lsu_addr_i[1:0])
                  || (w_outport && (lsu_funct3_i != WORD));

  // One extractor serves both the outport read (at accept) and memory reads.
  always_comb begin
    if (state_q == IDLE) begin
      w_lane = lsu_addr_i[1:0];
      w_f3   = lsu_funct3_i;
      w_src  = out_q;
    end else begin
      w_lane = lane_q;
      w_f3   = f3_q;
      w_src  = mem_rdata_i;
    end
  end

  load_align_ext u_align (
    .lane_i   (w_lane),
    .funct3_i (w_f3),
    .rdata_i  (w_src),
    .result_o (w_ext)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    out_d    = out_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    mwe_d    = mwe_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          store_d = lsu_store_i;
          f3_d    = lsu_funct3_i;
          lane_d  = lsu_addr_i[1:0];
          err_d   = 1'b0;
          if (w_acc_err) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (w_outport) begin
            state_d = DONE;
            if (lsu_store_i) out_d   = lsu_wdata_i;
            else             rdata_d = w_ext;
          end else begin
            state_d  = REQ;
            cnt_d    = 8'd0;
            maddr_d  = {lsu_addr_i[31:2], 2'b00};
            mbe_d    = byte_en(lsu_funct3_i[1:0], lsu_addr_i[1:0]);
            mwe_d    = lsu_store_i;
            mwdata_d = lane_rep(lsu_funct3_i[1:0], lsu_wdata_i);
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (store_q) begin
            state_d = DONE;
          end else if (mem_rvalid_i) begin
            state_d = DONE;
            rdata_d = w_ext;
          end else begin
            state_d = WAIT_RD;
            cnt_d   = 8'd0;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid_i) begin
          state_d = DONE;
          rdata_d = w_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      store_q  <= 1'b0;
      f3_q     <= 3'd0;
      lane_q   <= 2'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      out_q    <= 32'd0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      mbe_q    <= 4'd0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      mwe_q    <= mwe_d;
    end
  end

  assign lsu_ready_o = (state_q == IDLE);
  assign lsu_done_o  = (state_q == DONE);
  assign lsu_err_o   = (state_q == DONE) && err_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mwe_q;
  assign mem_addr_o  = maddr_q;
  assign mem_be_o    = mbe_q;
  assign mem_wdata_o = mwdata_q;
  assign out_port_o  = out_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// Scoreboard bench: directed cases then random accesses against a memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 255;
  localparam logic [31:0] OUTP    = 32'h0000fffc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid, lsu_ready, lsu_store, lsu_done, lsu_err;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, out_port;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.OUTPORT_ADDR(OUTP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_store_i(lsu_store),
    .lsu_funct3_i(lsu_funct3), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_done_o(lsu_done), .lsu_err_o(lsu_err), .lsu_rdata_o(lsu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .out_port_o(out_port)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] outp;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  exp_t        mon_e;
  logic [31:0] mem [0:255];
  logic [31:0] m_rdata, m_out;
  int          g_delay, r_delay, last_hold;
  bit          no_rvalid;
  int          n_cmp, n_err, n_done;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * lane);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return v & 32'h000000ff;
      3'b101:  return v & 32'h0000ffff;
      default: return word;
    endcase
  endfunction

  // Memory responder: gnt after g_delay waiting cycles, rvalid r_delay cycles after gnt.
  initial begin
    int   phase, cnt, rc;
    req_t cur, r;
    logic [7:0] rd_idx;
    phase = 0; cnt = 0; rc = 0; rd_idx = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (phase == 1 && !mem_req) phase = 0;
      if (phase == 0 && mem_req) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_req: actual req=1 addr %h required no request", mem_addr);
        end else begin
          r = req_q.pop_front();
          chk("mem_addr", mem_addr, r.addr);
          chk("mem_be", 32'(mem_be), 32'(r.be));
          chk("mem_we", 32'(mem_we), 32'(r.we));
          if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
        end
        cur.addr = mem_addr; cur.be = mem_be; cur.we = mem_we; cur.wdata = mem_wdata;
        cnt = 0; phase = 1;
      end else if (phase == 1) begin
        chk("req_stable_addr", mem_addr, cur.addr);
        chk("req_stable_be_we", {27'd0, mem_we, mem_be}, {27'd0, cur.we, cur.be});
      end
      if (phase == 1) begin
        if (cnt == g_delay) begin
          mem_gnt = 1'b1;
          last_hold = cnt + 1;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            phase = 0;
          end else if (no_rvalid) begin
            phase = 0;
          end else if (r_delay == 0) begin
            mem_rvalid = 1'b1; mem_rdata = mem[mem_addr[9:2]]; phase = 0;
          end else begin
            phase = 2; rc = 1; rd_idx = mem_addr[9:2];
          end
        end else begin
          cnt++;
        end
      end else if (phase == 2) begin
        if (rc == r_delay) begin
          mem_rvalid = 1'b1; mem_rdata = mem[rd_idx]; phase = 0;
        end else begin
          rc++;
        end
      end
    end
  end

  // Monitor: every lsu_done pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && lsu_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: actual lsu_done=1 required 0 (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("lsu_err", 32'(lsu_err), 32'(mon_e.err));
          chk("lsu_rdata", lsu_rdata, mon_e.rdata);
          chk("out_port", out_port, mon_e.outp);
          chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit wait_done);
    exp_t e;
    req_t r;
    bit   err, outp;
    int   sz, w;
    @(negedge clk);
    w = 0;
    while (!lsu_ready && w < 600) begin @(negedge clk); w++; end
    if (!lsu_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_wait: actual lsu_ready=0 required 1 within 600 cycles");
      return;
    end
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    outp = (addr[31:2] == OUTP[31:2]);
    err  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (st && (f3 == 3'd4 || f3 == 3'd5))
        || (addr % sz != 0) || (outp && sz != 4);
    e.acc = cyc;
    e.err = err;
    e.lat = 1;
    if (!err && outp) begin
      if (st) m_out = wd;
      else    m_rdata = m_out;
    end else if (!err) begin
      r.addr  = {addr[31:2], 2'b00};
      r.be    = 4'(((1 << sz) - 1) << addr[1:0]);
      r.we    = st;
      r.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
      req_q.push_back(r);
      if (g_delay >= int'(TIMEOUT)) begin
        e.err = 1'b1; e.lat = TIMEOUT + 1;
      end else if (st) begin
        e.lat = g_delay + 2;
      end else if (no_rvalid) begin
        e.err = 1'b1; e.lat = g_delay + 2 + TIMEOUT;
      end else begin
        e.lat = g_delay + 2 + r_delay;
        m_rdata = model_load(mem[addr[9:2]], addr[1:0], f3);
      end
    end
    e.rdata = m_rdata;
    e.outp  = m_out;
    exp_q.push_back(e);
    lsu_valid = 1'b1; lsu_store = st; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0; lsu_store = 1'($urandom); lsu_funct3 = 3'($urandom);
    lsu_addr = $urandom; lsu_wdata = $urandom;
    if (wait_done) begin
      w = 0;
      while (exp_q.size() != 0 && w < 600) begin @(negedge clk); w++; end
      if (exp_q.size() != 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_wait: actual no lsu_done required one within 600 cycles");
        exp_q.delete();
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_out_port", out_port, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  // Asynchronous reset in the middle of an access; the model restarts too.
  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(lsu_ready), 32'd1);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_done", 32'(lsu_done), 32'd0);
    exp_q.delete();
    m_rdata = 32'd0;
    m_out   = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          n0;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sz;
    n_cmp = 0; n_err = 0; n_done = 0; last_hold = 0;
    g_delay = 0; r_delay = 0; no_rvalid = 1'b0;
    m_rdata = 32'd0; m_out = 32'd0;
    lsu_valid = 1'b0; lsu_store = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    mem[8'h40] = 32'hdeadbeef;
    access(1'b0, 3'b010, 32'h100, $urandom, 1'b1);
    mem[8'h40] = 32'h80112233;
    access(1'b0, 3'b000, 32'h103, $urandom, 1'b1);
    chk("lb_sign", lsu_rdata, 32'hffffff80);
    access(1'b0, 3'b100, 32'h103, $urandom, 1'b1);
    chk("lbu_zero", lsu_rdata, 32'h00000080);

    g_delay = 3;
    access(1'b1, 3'b001, 32'h202, 32'h0000abcd, 1'b1);
    chk("sh_req_hold_cycles", 32'(last_hold), 32'd4);
    g_delay = 0;

    access(1'b1, 3'b010, OUTP, 32'h12345678, 1'b1);
    access(1'b0, 3'b010, OUTP, $urandom, 1'b1);
    chk("outport_readback", lsu_rdata, 32'h12345678);
    access(1'b0, 3'b000, OUTP, $urandom, 1'b1);

    access(1'b0, 3'b010, 32'h101, $urandom, 1'b1);
    access(1'b1, 3'b100, 32'h104, $urandom, 1'b1);
    access(1'b0, 3'b011, 32'h108, $urandom, 1'b1);
    chk("err_keeps_rdata", lsu_rdata, 32'h12345678);

    no_rvalid = 1'b1;
    access(1'b0, 3'b010, 32'h020, $urandom, 1'b1);
    no_rvalid = 1'b0;
    g_delay = 1000;
    access(1'b1, 3'b010, 32'h024, $urandom, 1'b1);
    g_delay = 0;

    // Reset while in WAIT_RD; the read data arrives afterwards and must be ignored.
    r_delay = 30;
    access(1'b0, 3'b010, 32'h030, $urandom, 1'b0);
    @(negedge clk);
    reset_pulse();
    n0 = n_done;
    repeat (40) @(negedge clk);
    chk("late_rvalid_no_done", 32'(n_done - n0), 32'd0);
    chk("late_rvalid_rdata", lsu_rdata, 32'd0);
    r_delay = 0;

    // Reset while a request is still waiting for gnt.
    g_delay = 10;
    access(1'b1, 3'b010, 32'h034, $urandom, 1'b0);
    @(negedge clk);
    reset_pulse();
    g_delay = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 7) == 0) a = OUTP | 32'($urandom_range(0, 3));
      else                           a = 32'($urandom_range(0, 32'h3ff));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      g_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      access(st, f3, a, $urandom, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
